// File: rtl/mux4_rr_scheduler_if.sv
// Handshake bundle between four requesters and one downstream consumer for mux4_rr_scheduler.
// master = producer/consumer environment side, slave = scheduler side.
interface mux4_rr_scheduler_if #(
  parameter int W = 4
);
  logic [3:0]   in_valid;
  logic [W-1:0] in_data0;
  logic [W-1:0] in_data1;
  logic [W-1:0] in_data2;
  logic [W-1:0] in_data3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux4_rr_scheduler.sv
// Four-way round-robin scheduler feeding a one-entry registered output stage.
// Define MUX4_RR_PRIORITY0_EN to give requester 0 strict priority over round-robin 1..3.
module mux4_rr_scheduler #(
  parameter int W = 4
) (
  input logic              clk,
  input logic              rst,
  mux4_rr_scheduler_if.slave bus
);

  logic [1:0]   ptr_q;
  logic         valid_q;
  logic [W-1:0] data_q;
  logic [1:0]   sel_q;

  logic         load_en;
  logic [1:0]   gnt;
  logic         gnt_vld;
  logic [3:0]   ready;
  logic         xfer;
  logic [W-1:0] mux_data;

  // Returns {found, index}; scans ptr+1, ptr+2, ptr+3, ptr so the last grant ranks lowest.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0]  res;
    logic [1:0]  idx;
    res = '0;
    for (int unsigned k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
`ifdef MUX4_RR_PRIORITY0_EN
    if (bus.in_valid[0]) begin
      gnt     = 2'd0;
      gnt_vld = 1'b1;
    end else begin
      {gnt_vld, gnt} = rr_pick(bus.in_valid & 4'b1110, ptr_q);
    end
`else
    {gnt_vld, gnt} = rr_pick(bus.in_valid, ptr_q);
`endif
  end

  assign load_en = !valid_q || bus.out_ready;

  always_comb begin
    ready = '0;
    if (!rst && load_en && gnt_vld && bus.in_valid[gnt]) ready[gnt] = 1'b1;
  end

  assign xfer = |ready;

  always_comb begin
    mux_data = bus.in_data0;
    case (gnt)
      2'd0: mux_data = bus.in_data0;
      2'd1: mux_data = bus.in_data1;
      2'd2: mux_data = bus.in_data2;
      2'd3: mux_data = bus.in_data3;
      default: mux_data = bus.in_data0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= 2'd3;
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q  <= mux_data;
      sel_q   <= gnt;
`ifdef MUX4_RR_PRIORITY0_EN
      if (gnt != 2'd0) ptr_q <= gnt;
`else
      ptr_q   <= gnt;
`endif
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule
